// File: rtl/sclk_burst_scheduler_if.sv
// Request/burst bus between the requesters and the shared sclk burst scheduler.
interface sclk_burst_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LENW = 16
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req;
  logic [4*NREQ-1:0]    div_in;
  logic [LENW*NREQ-1:0] len_in;
  logic                 abort;
  logic                 sclk;
  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       gnt_id;
  logic                 busy;
  logic                 done;
  logic                 aborted;

  modport master (
    output req, div_in, len_in, abort,
    input  sclk, grant, gnt_id, busy, done, aborted
  );

  modport slave (
    input  req, div_in, len_in, abort,
    output sclk, grant, gnt_id, busy, done, aborted
  );
endinterface

// File: rtl/sclk_burst_scheduler.sv
// Round-robin scheduler sharing one divided-clock generator among NREQ requesters.
// Each grant produces exactly L sclk periods at divisor d (high for floor(d/2) cycles).
module sclk_burst_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LENW = 16
) (
  input logic                   clock_in,
  input logic                   rstn,
  sclk_burst_scheduler_if.slave sched_if
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  state_e          r_state, w_state_next;
  logic [3:0]      r_div, r_phase;
  logic [LENW-1:0] r_len, r_period;
  logic            r_sclk, r_done, r_aborted;
  logic [NREQ-1:0] r_grant;
  logic [IDW-1:0]  r_gnt_id, r_last_id;

  logic [3:0]      w_div_d, w_phase_d;
  logic [LENW-1:0] w_len_d, w_period_d;
  logic            w_sclk_d, w_done_d, w_aborted_d;
  logic [NREQ-1:0] w_grant_d;
  logic [IDW-1:0]  w_gnt_id_d, w_last_id_d;

  logic            w_found;
  logic [IDW-1:0]  w_pick;
  logic [3:0]      w_div_sel;
  logic [LENW-1:0] w_len_sel;
  logic            w_phase_wrap, w_last_cycle;
  logic [3:0]      w_next_phase;

  assign w_phase_wrap = (r_phase == r_div - 4'd1);
  assign w_last_cycle = w_phase_wrap && (r_period == r_len - LENW'(1));
  assign w_next_phase = w_phase_wrap ? 4'd0 : r_phase + 4'd1;

  // Round-robin pick: first set req bit searching upward from last_id+1, wrapping.
  always_comb begin
    int unsigned v_idx;
    w_found   = 1'b0;
    w_pick    = '0;
    w_div_sel = '0;
    w_len_sel = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      v_idx = (32'(r_last_id) + k) % NREQ;
      if (!w_found && sched_if.req[v_idx]) begin
        w_found   = 1'b1;
        w_pick    = IDW'(v_idx);
        w_div_sel = sched_if.div_in[v_idx*4 +: 4];
        w_len_sel = sched_if.len_in[v_idx*LENW +: LENW];
      end
    end
  end

  // State register.
  always_ff @(posedge clock_in) begin
    if (!rstn) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Next-state logic; abort only matters while running.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_found) w_state_next = StRun;
      StRun:   if (sched_if.abort || w_last_cycle) w_state_next = StGap;
      StGap:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Next values for the burst datapath and registered outputs.
  always_comb begin
    w_div_d     = r_div;
    w_len_d     = r_len;
    w_phase_d   = r_phase;
    w_period_d  = r_period;
    w_sclk_d    = r_sclk;
    w_grant_d   = r_grant;
    w_gnt_id_d  = r_gnt_id;
    w_last_id_d = r_last_id;
    w_done_d    = r_done;
    w_aborted_d = r_aborted;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_div_d     = (w_div_sel < 4'd2) ? 4'd2 : w_div_sel;
          w_len_d     = (w_len_sel == '0) ? LENW'(1) : w_len_sel;
          w_phase_d   = '0;
          w_period_d  = '0;
          w_sclk_d    = 1'b1;  // d >= 2, so the first cycle is always high
          w_grant_d   = NREQ'(1) << w_pick;
          w_gnt_id_d  = w_pick;
          w_last_id_d = w_pick;
        end
      end
      StRun: begin
        if (sched_if.abort || w_last_cycle) begin
          w_sclk_d    = 1'b0;
          w_grant_d   = '0;
          w_done_d    = 1'b1;
          w_aborted_d = sched_if.abort;
        end else begin
          w_phase_d = w_next_phase;
          w_sclk_d  = (w_next_phase < (r_div >> 1));
          if (w_phase_wrap) w_period_d = r_period + LENW'(1);
        end
      end
      StGap: begin
        w_done_d    = 1'b0;
        w_aborted_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers; a reset mid-burst drops everything without a done pulse.
  always_ff @(posedge clock_in) begin
    if (!rstn) begin
      r_div     <= '0;
      r_len     <= '0;
      r_phase   <= '0;
      r_period  <= '0;
      r_sclk    <= 1'b0;
      r_grant   <= '0;
      r_gnt_id  <= '0;
      r_last_id <= IDW'(NREQ - 1);
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_div     <= w_div_d;
      r_len     <= w_len_d;
      r_phase   <= w_phase_d;
      r_period  <= w_period_d;
      r_sclk    <= w_sclk_d;
      r_grant   <= w_grant_d;
      r_gnt_id  <= w_gnt_id_d;
      r_last_id <= w_last_id_d;
      r_done    <= w_done_d;
      r_aborted <= w_aborted_d;
    end
  end

  assign sched_if.sclk    = r_sclk;
  assign sched_if.grant   = r_grant;
  assign sched_if.gnt_id  = r_gnt_id;
  assign sched_if.busy    = (r_state != StIdle);
  assign sched_if.done    = r_done;
  assign sched_if.aborted = r_aborted;
endmodule

// File: tb/tb_sclk_burst_scheduler.sv
// Bench for sclk_burst_scheduler: burst-level reference model checked every cycle,
// directed scenarios pinned with literal sclk patterns, then randomized traffic.
module tb_sclk_burst_scheduler;
  localparam int unsigned NREQ = 4;
  localparam int unsigned LENW = 16;

  logic clock_in = 1'b0;
  logic rstn     = 1'b0;
  always #5 clock_in = ~clock_in;

  sclk_burst_scheduler_if #(.NREQ(NREQ), .LENW(LENW)) bus ();

  sclk_burst_scheduler #(.NREQ(NREQ), .LENW(LENW)) dut (
    .clock_in (clock_in),
    .rstn     (rstn),
    .sched_if (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst-level model: a burst is L*d RUN cycles, cycle n has sclk = (n mod d) < d/2.
  int              m_mode;  // 0 idle, 1 run, 2 gap
  int              m_d, m_L, m_cnt, m_last, m_gid;
  logic            m_sclk, m_done, m_aborted;
  logic [NREQ-1:0] m_grant;

  task automatic model_step();
    int   pick;
    int   dv, ln;
    if (!rstn) begin
      m_mode = 0; m_sclk = 1'b0; m_grant = '0; m_gid = 0; m_done = 1'b0;
      m_aborted = 1'b0; m_last = NREQ - 1; m_cnt = 0;
    end else begin
      case (m_mode)
        0: begin
          pick = -1;
          for (int k = 1; k <= NREQ; k++) begin
            if (pick < 0 && bus.req[(m_last + k) % NREQ]) pick = (m_last + k) % NREQ;
          end
          if (pick >= 0) begin
            dv = int'(bus.div_in[4*pick +: 4]);
            ln = int'(bus.len_in[LENW*pick +: LENW]);
            m_d = (dv < 2) ? 2 : dv;
            m_L = (ln == 0) ? 1 : ln;
            m_cnt = 0; m_mode = 1; m_sclk = 1'b1;
            m_grant = '0; m_grant[pick] = 1'b1;
            m_gid = pick; m_last = pick;
          end
        end
        1: begin
          if (bus.abort) begin
            m_mode = 2; m_sclk = 1'b0; m_grant = '0; m_done = 1'b1; m_aborted = 1'b1;
          end else if (m_cnt == m_L * m_d - 1) begin
            m_mode = 2; m_sclk = 1'b0; m_grant = '0; m_done = 1'b1; m_aborted = 1'b0;
          end else begin
            m_cnt++;
            m_sclk = ((m_cnt % m_d) < (m_d / 2));
          end
        end
        default: begin
          m_mode = 0; m_done = 1'b0; m_aborted = 1'b0;
        end
      endcase
    end
  endtask

  // Observations used by the directed scenarios.
  logic [63:0]     cap_bits;
  int              cap_len, done_cnt, abort_cnt, cyc;
  int              ord[$];
  int              ord_t[$];
  logic [NREQ-1:0] prev_grant = '0;

  task automatic clr_cap();
    cap_bits = '0; cap_len = 0; done_cnt = 0; abort_cnt = 0;
    ord.delete(); ord_t.delete();
  endtask

  // Compare process: advance the model at each edge, check DUT just after it.
  initial begin
    cyc = 0;
    clr_cap();
    forever begin
      @(posedge clock_in);
      model_step();
      #1;
      cyc++;
      chk("sclk",    64'(bus.sclk),    64'(m_sclk));
      chk("grant",   64'(bus.grant),   64'(m_grant));
      chk("gnt_id",  64'(bus.gnt_id),  64'(m_gid));
      chk("busy",    64'(bus.busy),    64'(m_mode != 0));
      chk("done",    64'(bus.done),    64'(m_done));
      chk("aborted", 64'(bus.aborted), 64'(m_aborted));
      if (bus.grant != '0) begin
        cap_bits = {cap_bits[62:0], bus.sclk};
        cap_len++;
        if (prev_grant == '0) begin
          ord.push_back(int'(bus.gnt_id));
          ord_t.push_back(cyc);
        end
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (bus.aborted === 1'b1) abort_cnt++;
      end
      prev_grant = bus.grant;
    end
  end

  task automatic set_req(input int i, input int dv, input int ln);
    bus.div_in[4*i +: 4]       = 4'(dv);
    bus.len_in[LENW*i +: LENW] = LENW'(ln);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clock_in);
      n++;
    end
    chk(tag, 64'(bus.busy), 64'(0));
  endtask

  task automatic start_one(input logic [NREQ-1:0] r);
    bus.req = r;
    @(negedge clock_in);
    bus.req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.req = '0; bus.div_in = '0; bus.len_in = '0; bus.abort = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clock_in);
    rstn = 1'b1;
    chk("reset_busy",  64'(bus.busy),  64'(0));
    chk("reset_grant", 64'(bus.grant), 64'(0));
    chk("reset_sclk",  64'(bus.sclk),  64'(0));

    // Single burst d=4, L=3.
    clr_cap();
    set_req(0, 4, 3);
    start_one(4'b0001);
    chk("t1_grant", 64'(bus.grant), 64'(4'b0001));
    wait_idle(60, "t1_idle");
    chk("t1_len",   64'(cap_len), 64'(12));
    chk("t1_bits",  64'(cap_bits[11:0]), 64'(12'b110011001100));
    chk("t1_done",  64'(done_cnt), 64'(1));
    chk("t1_abort", 64'(abort_cnt), 64'(0));

    // Odd divisor, then clamped divisor and length.
    clr_cap();
    set_req(0, 5, 2);
    start_one(4'b0001);
    wait_idle(60, "t2a_idle");
    chk("t2a_len",  64'(cap_len), 64'(10));
    chk("t2a_bits", 64'(cap_bits[9:0]), 64'(10'b1100011000));
    clr_cap();
    set_req(0, 1, 0);
    start_one(4'b0001);
    wait_idle(60, "t2b_idle");
    chk("t2b_len",  64'(cap_len), 64'(2));
    chk("t2b_bits", 64'(cap_bits[1:0]), 64'(2'b10));

    // Round robin from reset with all requesters asking.
    rstn = 1'b0;
    @(negedge clock_in);
    rstn = 1'b1;
    clr_cap();
    for (int i = 0; i < NREQ; i++) set_req(i, 2, 1);
    bus.req = 4'b1111;
    begin
      int n = 0;
      while (ord.size() < 5 && n < 80) begin
        @(negedge clock_in);
        n++;
      end
    end
    bus.req = '0;
    wait_idle(60, "t3_idle");
    chk("t3_count", 64'(ord.size() >= 5), 64'(1));
    for (int i = 0; i < 5 && i < ord.size(); i++)
      chk($sformatf("t3_order%0d", i), 64'(ord[i]), 64'(exp_ord[i]));
    for (int i = 1; i < 5 && i < ord_t.size(); i++)
      chk($sformatf("t3_spacing%0d", i), 64'(ord_t[i] - ord_t[i-1]), 64'(4));

    // Abort in the 8th RUN cycle of a d=6, L=4 burst.
    clr_cap();
    set_req(0, 6, 4);
    start_one(4'b0001);
    repeat (7) @(negedge clock_in);
    bus.abort = 1'b1;
    @(negedge clock_in);
    bus.abort = 1'b0;
    chk("t4_sclk",    64'(bus.sclk),    64'(0));
    chk("t4_grant",   64'(bus.grant),   64'(0));
    chk("t4_done",    64'(bus.done),    64'(1));
    chk("t4_aborted", 64'(bus.aborted), 64'(1));
    wait_idle(60, "t4_idle");
    chk("t4_len",  64'(cap_len), 64'(8));
    chk("t4_bits", 64'(cap_bits[7:0]), 64'(8'b11100011));
    clr_cap();
    set_req(0, 2, 2);
    start_one(4'b0001);
    wait_idle(60, "t4b_idle");
    chk("t4b_bits",  64'(cap_bits[3:0]), 64'(4'b1010));
    chk("t4b_abort", 64'(abort_cnt), 64'(0));

    // Inputs churn during a burst; burst keeps its latched d=8, L=2.
    clr_cap();
    set_req(1, 8, 2);
    start_one(4'b0010);
    repeat (6) begin
      set_req(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 9)));
      @(negedge clock_in);
    end
    wait_idle(60, "t5_idle");
    chk("t5_id",   64'(ord.size() > 0 ? ord[0] : -1), 64'(1));
    chk("t5_len",  64'(cap_len), 64'(16));
    chk("t5_bits", 64'(cap_bits[15:0]), 64'(16'b1111000011110000));

    // Reset in the 5th RUN cycle.
    clr_cap();
    set_req(2, 4, 5);
    start_one(4'b0100);
    repeat (4) @(negedge clock_in);
    rstn = 1'b0;
    @(negedge clock_in);
    rstn = 1'b1;
    chk("t6_grant",  64'(bus.grant),  64'(0));
    chk("t6_sclk",   64'(bus.sclk),   64'(0));
    chk("t6_busy",   64'(bus.busy),   64'(0));
    chk("t6_done",   64'(bus.done),   64'(0));
    chk("t6_gnt_id", 64'(bus.gnt_id), 64'(0));
    for (int i = 0; i < NREQ; i++) set_req(i, 2, 1);
    start_one(4'b1111);
    chk("t6_next_id", 64'(bus.gnt_id), 64'(0));
    wait_idle(60, "t6_idle");
    chk("t6_done_cnt", 64'(done_cnt), 64'(1));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock_in);
      rstn = ($urandom_range(0, 599) != 0);
      bus.req = NREQ'($urandom) & NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
      bus.abort = ($urandom_range(0, 49) == 0);
    end
    @(negedge clock_in);
    rstn = 1'b1; bus.req = '0; bus.abort = 1'b0;
    repeat (4) @(negedge clock_in);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sclk_burst_scheduler.md
# sclk_burst_scheduler

Shares a single divided-clock generator among NREQ requesters (ADC front-end channels, calibration sweep, host diagnostics) in the SEEG acquisition path. Each requester asks for a burst of a given number of serial-clock periods at its own divisor. The block arbitrates round-robin and latches the winner's divisor and length. It then produces exactly that many sclk periods with the same duty-cycle rule as the existing divider: high for the first floor(d/2) cycles of each period. A new burst can never start, and the divisor can never change, mid-period.

## Interface
- NREQ, 4: number of requesters (2..8).
- LENW, 16: burst-length width in periods.
- clock_in  input  1  system clock; all logic on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- req  input  NREQ  per-requester burst request, level; held until grant.
- div_in  input  4*NREQ  packed divisors; requester i uses bits [4i+3:4i].
- len_in  input  LENW*NREQ  packed burst lengths in sclk periods.
- abort  input  1  terminate current burst at the next edge.
- sclk  output  1  registered divided clock.
- grant  output  NREQ  one-hot, high for the whole burst of the granted requester.
- gnt_id  output  $clog2(NREQ)  index of the current or last grant.
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse at end of burst, normal or aborted.
- aborted  output  1  valid with done; 1 when the burst ended by abort.

## Operation
- States: IDLE, RUN, GAP.
- **IDLE:** if any req bit is set, pick the first set bit searching from last_id+1 upward with wrap-around. In the same edge:
  - latch d = clamp(div_in[i]), where values 0 and 1 become 2;
  - latch L = len_in[i], where 0 becomes 1;
  - set grant[i] and gnt_id=i, last_id=i;
  - clear phase and period counters, set sclk<=1 (d>=2 so floor(d/2)>=1), and go to RUN.
- **RUN:** phase counts 0..d-1 and wraps. sclk <= (next_phase < d/2), using an unsigned 4-bit compare.
  - When phase wraps, the period counter increments.
  - When phase==d-1 and period==L-1: go to GAP, clear sclk and grant, pulse done, aborted=0.
- **abort in RUN** takes priority over normal completion: go to GAP, clear sclk and grant, pulse done, aborted=1.
- **abort outside RUN** is ignored.
- **GAP:** one cycle, then IDLE. done and aborted are cleared on leaving GAP.
- req, div_in and len_in are sampled only in IDLE. Changes during RUN or GAP have no effect on the active burst.
- Dropping req during RUN does not shorten the burst.
- Round-robin pointer: last_id resets to NREQ-1, so requester 0 wins first after reset.
- Reset, including mid-burst: state=IDLE, sclk=0, grant=0, gnt_id=0, busy=0, done=0, aborted=0, last_id=NREQ-1, counters=0. No done pulse is produced for a burst killed by reset.

## Timing
- Request-to-grant latency: req high in IDLE cycle T gives grant, busy and sclk=1 from cycle T+1.
- A burst occupies exactly L*d cycles of RUN, with sclk high floor(d/2) cycles and low ceil(d/2) cycles per period.
- The done pulse is in the GAP cycle immediately after the last RUN cycle.
- Back-to-back bursts: the next grant is at the earliest 2 cycles after the last RUN cycle (GAP, then IDLE sample).
- Abort asserted in RUN cycle T: sclk=0, grant=0, done=1 in cycle T+1. A partial period is allowed.

## Test plan
- Reset and single burst:
  - stimulus: rstn low for 3 cycles, then req=0001, div 4, len 3;
  - response: grant=0001 one cycle after req; sclk pattern 1100 repeated 3 times (12 cycles); done pulse, aborted=0, busy low 2 cycles later.
- Odd divisor and clamp:
  - stimulus: div 5, len 2, then div 1, len 0;
  - response: first burst 11000 11000; second burst treated as d=2, L=1, giving sclk 10.
- Round-robin fairness:
  - stimulus: req=1111 held permanently, all len 1, div 2;
  - response: grant order 0,1,2,3,0; each burst separated by 2 idle cycles.
- Abort mid-period:
  - stimulus: div 6, len 4, abort pulsed on the 8th RUN cycle;
  - response: sclk=0 and grant=0 next cycle; done=1 with aborted=1; later bursts are unaffected.
- Input changes during a burst:
  - stimulus: req=0010 granted with div 8, len 2; div_in and len_in toggled and req dropped during RUN;
  - response: exactly 16 RUN cycles at d=8.
- Reset mid-burst:
  - stimulus: rstn low in the 5th RUN cycle;
  - response: all outputs 0 next cycle, no done pulse, requester 0 wins the next arbitration.
